// File: rtl/conv_stream_seq_pkg.sv
// conv_pkg: shared definitions for the streaming convolution sequencer.
//   - default lane/accumulator/block-count widths and tap count
//   - sequencer state enum
//   - lane_get: extract lane i (lw bits wide) from a packed word, x0/h0 in LSBs
package conv_pkg;
  localparam int LANE_W_DEF = 5;
  localparam int ACC_W_DEF  = 12;
  localparam int NBLK_W_DEF = 8;
  localparam int TAPS       = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    FLUSH,
    DONE
  } state_e;

  function automatic int unsigned lane_get(input logic [63:0] w,
                                           input int unsigned lw,
                                           input int unsigned i);
    logic [63:0] m;
    m = (64'd1 << lw) - 64'd1;
    return 32'((w >> (lw * i)) & m);
  endfunction
endpackage

// File: rtl/conv_stream_seq_if.sv
// Handshake bundle for conv_stream_seq: command port, input block stream and
// output sample stream.
//   slave  : the sequencer side (accepts cmd/in, drives out)
//   master : the host/downstream side
interface conv_stream_seq_if
  import conv_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int NBLK_W = NBLK_W_DEF
) ();
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [TAPS*LANE_W-1:0]   cmd_kernel;
  logic [NBLK_W-1:0]        cmd_nblk;
  logic                     in_valid;
  logic                     in_ready;
  logic [TAPS*LANE_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W-1:0]         out_data;
  logic                     out_last;

  modport slave (
    input  cmd_valid, cmd_kernel, cmd_nblk, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last
  );

  modport master (
    output cmd_valid, cmd_kernel, cmd_nblk, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_stream_seq_block4.sv
// conv_block4: combinational full linear convolution of a 4-sample block with
// a 4-tap kernel. y_o[k] = sum over i+j=k of x[i]*h[j], k = 0..6, unsigned,
// computed at ACC_W bits (wide enough that nothing is truncated).
//   x_i : packed samples x0..x3 (x0 in LSBs)
//   h_i : packed taps h0..h3 (h0 in LSBs)
//   y_o : seven partial outputs y0..y6
module conv_block4
  import conv_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [TAPS*LANE_W-1:0]           x_i,
  input  logic [TAPS*LANE_W-1:0]           h_i,
  output logic [2*TAPS-2:0][ACC_W-1:0]     y_o
);
  always_comb begin
    y_o = '0;
    for (int i = 0; i < TAPS; i++) begin
      for (int j = 0; j < TAPS; j++) begin
        y_o[i+j] = y_o[i+j] + ACC_W'(lane_get(64'(x_i), LANE_W, i) *
                                    lane_get(64'(h_i), LANE_W, j));
      end
    end
  end
endmodule

// File: rtl/conv_stream_seq.sv
// conv_stream_seq: runs a 4-tap linear convolution over a stream of N packed
// 4-sample blocks using one conv_block4 pass per block, with overlap-add of
// the 3-sample block tail into the next block and a 3-sample flush at the end.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cmd (kernel, nblk), in (block), out (sample, last) handshakes
//   busy     : high in any state other than IDLE
//   done     : one-cycle pulse after the last sample is accepted
module conv_stream_seq
  import conv_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int NBLK_W = NBLK_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  conv_stream_seq_if.slave   bus,
  output logic               busy,
  output logic               done
);
  state_e                         state_q, state_d;
  logic [TAPS*LANE_W-1:0]         kern_q, kern_d;
  logic [NBLK_W-1:0]              cnt_q, cnt_d;
  logic [1:0]                     idx_q, idx_d;
  logic [TAPS-1:0][ACC_W-1:0]     stg_q, stg_d;
  logic [TAPS-2:0][ACC_W-1:0]     ov_q, ov_d;
  logic [ACC_W-1:0]               dout_q, dout_d;
  logic                           last_q, last_d;
  logic [2*TAPS-2:0][ACC_W-1:0]   y;

  conv_block4 #(.LANE_W(LANE_W), .ACC_W(ACC_W)) u_blk (
    .x_i (bus.in_data),
    .h_i (kern_q),
    .y_o (y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kern_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      stg_q   <= '0;
      ov_q    <= '0;
      dout_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kern_q  <= kern_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stg_q   <= stg_d;
      ov_q    <= ov_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
    end
  end

  // dout_q is loaded one cycle ahead with whatever sample is presented next,
  // so out_data is always a plain register output.
  always_comb begin
    state_d = state_q;
    kern_d  = kern_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stg_d   = stg_q;
    ov_d    = ov_q;
    dout_d  = dout_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          kern_d  = bus.cmd_kernel;
          cnt_d   = bus.cmd_nblk;
          ov_d    = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          state_d = (bus.cmd_nblk != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          stg_d[0] = y[0] + ov_q[0];
          stg_d[1] = y[1] + ov_q[1];
          stg_d[2] = y[2] + ov_q[2];
          stg_d[3] = y[3];
          ov_d[0]  = y[4];
          ov_d[1]  = y[5];
          ov_d[2]  = y[6];
          dout_d   = y[0] + ov_q[0];
          cnt_d    = cnt_q - 1'b1;
          idx_d    = '0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (idx_q == 2'd3) begin
            idx_d = '0;
            if (cnt_q != '0) begin
              state_d = LOAD;
            end else begin
              dout_d  = ov_q[0];
              state_d = FLUSH;
            end
          end else begin
            idx_d  = idx_q + 2'd1;
            dout_d = stg_q[idx_q + 2'd1];
          end
        end
      end
      FLUSH: begin
        if (bus.out_ready) begin
          if (idx_q == 2'd2) begin
            last_d  = 1'b0;
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 2'd1;
            dout_d = ov_q[idx_q + 2'd1];
            last_d = (idx_q == 2'd1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == EMIT) || (state_q == FLUSH);
  assign bus.out_data  = dout_q;
  assign bus.out_last  = last_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
endmodule

// File: tb/tb_conv_stream_seq.sv
// Self-checking bench for conv_stream_seq. Each test task drives one or more
// commands through do_cmd (which only records observations) and compares the
// recorded output stream and timing against directed constants or a
// whole-stream convolution model.
module tb_conv_stream_seq;
  logic clk = 1'b0;
  logic rst;
  logic busy, done;

  always #5 clk = ~clk;

  conv_stream_seq_if #(.LANE_W(5), .ACC_W(12), .NBLK_W(8)) bus ();

  conv_stream_seq #(.LANE_W(5), .ACC_W(12), .NBLK_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy),
    .done (done)
  );

  int tests_run = 0;
  int fails     = 0;

  // observations from the last do_cmd
  int   got_q[$];
  int   last_idx, done_cyc, last_cyc, hold_viol, done_cnt, inr_seen, outv_seen;
  logic first_inr, first_done, cmdrdy_after, done_after, cmd_acc;
  bit   timed_out;

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  // Convolution of the kernel with the whole concatenated input stream.
  function automatic void model(input logic [19:0] k, input int n,
                                input logic [19:0] blk[$], output int y[$]);
    int x[$];
    int s;
    y = {};
    for (int b = 0; b < n; b++)
      for (int i = 0; i < 4; i++) x.push_back(int'((blk[b] >> (5*i)) & 20'd31));
    if (n == 0) return;
    for (int m = 0; m < 4*n + 3; m++) begin
      s = 0;
      for (int j = 0; j < 4; j++)
        if (m - j >= 0 && m - j < 4*n) s += int'((k >> (5*j)) & 20'd31) * x[m-j];
      y.push_back(s);
    end
  endfunction

  function automatic bit same(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int first_diff(input int a[$], input int b[$]);
    foreach (a[i]) if (i >= b.size() || a[i] != b[i]) return i;
    return a.size();
  endfunction

  // Runs one command starting at a negedge; returns at a negedge. Records the
  // output stream and handshake timing but performs no checks itself.
  task automatic do_cmd(input logic [19:0] kern, input int n, input logic [19:0] blk[$],
                        input bit rnd_ready, input int stall_at, input int abort_at);
    int bi, stall_cnt;
    bit held, fin, rdy;
    logic [11:0] hd;
    logic hl;
    bi = 0; stall_cnt = 0; held = 0; fin = 0; hd = '0; hl = 0;
    got_q = {}; last_idx = -1; done_cyc = -1; last_cyc = -1; hold_viol = 0;
    done_cnt = 0; inr_seen = 0; outv_seen = 0; timed_out = 1;
    cmdrdy_after = 0; done_after = 0; first_inr = 0; first_done = 0;
    cmd_acc = bus.cmd_ready;
    bus.cmd_valid = 1; bus.cmd_kernel = kern; bus.cmd_nblk = 8'(n);
    bus.in_valid = 0; bus.out_ready = 0;
    @(posedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      bus.cmd_valid = 0; bus.cmd_kernel = 20'($urandom); bus.cmd_nblk = 8'($urandom);
      if (cyc == 0) begin first_inr = bus.in_ready; first_done = done; end
      if (fin) begin
        cmdrdy_after = bus.cmd_ready; done_after = done; timed_out = 0;
        return;
      end
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        bus.in_valid = 0; bus.out_ready = 0; timed_out = 0;
        return;
      end
      if (held && (bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_last !== hl))
        hold_viol++;
      if (bus.out_valid && bus.in_ready) hold_viol++;
      if (bus.in_ready) inr_seen++;
      if (bus.out_valid) outv_seen++;
      bus.in_valid = (bi < n);
      bus.in_data  = (bi < n) ? blk[bi] : 20'($urandom);
      rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall_at >= 0 && got_q.size() == stall_at && bus.out_valid && stall_cnt < 5) begin
        rdy = 0; stall_cnt++;
      end
      bus.out_ready = rdy;
      if (bus.in_valid && bus.in_ready) bi++;
      held = bus.out_valid && !bus.out_ready;
      hd = bus.out_data; hl = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(int'(bus.out_data));
        if (bus.out_last) last_idx = got_q.size() - 1;
        last_cyc = cyc;
      end
      if (done) begin done_cyc = cyc; done_cnt++; fin = 1; end
    end
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    rst = 1;
    bus.cmd_valid = 0; bus.in_valid = 0; bus.out_ready = 0;
    bus.cmd_kernel = '0; bus.cmd_nblk = '0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, busy, done};
    tests_run++;
    if (obs !== {1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_values: got %b want %b", obs, 18'b100_000000000000_000);
    end
    rst = 0;
  endtask

  task automatic test_identity(input string tag);
    int exp[$];
    logic [19:0] b[$];
    exp = '{3, 5, 7, 9, 0, 0, 0};
    b = '{pk(3, 5, 7, 9)};
    do_cmd(pk(1, 0, 0, 0), 1, b, 0, -1, -1);
    tests_run++;
    if (!same(got_q, exp)) begin
      fails++;
      $display("FAIL %s seq: got %0d samples, first diff at %0d, want %p", tag, got_q.size(),
               first_diff(exp, got_q), exp);
    end
    tests_run++;
    if (last_idx != 6) begin fails++; $display("FAIL %s last_idx: got %0d want 6", tag, last_idx); end
    tests_run++;
    if (timed_out || done_cyc - last_cyc != 1) begin
      fails++; $display("FAIL %s done_latency: got %0d want 1 (timeout=%0d)", tag, done_cyc - last_cyc, timed_out);
    end
    tests_run++;
    if (first_inr !== 1'b1 || cmd_acc !== 1'b1) begin
      fails++; $display("FAIL %s in_ready_after_cmd: got %b want 1", tag, first_inr);
    end
    tests_run++;
    if (cmdrdy_after !== 1'b1 || done_after !== 1'b0 || done_cnt != 1) begin
      fails++; $display("FAIL %s cmd_ready_after_done: got %b/%b cnt %0d want 1/0 cnt 1", tag,
                        cmdrdy_after, done_after, done_cnt);
    end
  endtask

  task automatic test_overlap();
    int exp[$];
    logic [19:0] b[$];
    exp = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1};
    b = '{pk(1, 1, 1, 1), pk(1, 1, 1, 1)};
    do_cmd(pk(1, 1, 1, 1), 2, b, 0, -1, -1);
    tests_run++;
    if (!same(got_q, exp)) begin
      fails++; $display("FAIL overlap seq: got %p want %p", got_q, exp);
    end
    tests_run++;
    if (last_idx != 10) begin fails++; $display("FAIL overlap last_idx: got %0d want 10", last_idx); end
  endtask

  task automatic test_fullscale();
    int exp[$];
    logic [19:0] b[$];
    exp = '{961, 1922, 2883, 3844, 3844, 3844, 3844, 3844, 2883, 1922, 961};
    b = '{pk(31, 31, 31, 31), pk(31, 31, 31, 31)};
    do_cmd(pk(31, 31, 31, 31), 2, b, 0, -1, -1);
    tests_run++;
    if (!same(got_q, exp)) begin
      fails++; $display("FAIL fullscale seq: got %p want %p", got_q, exp);
    end
  endtask

  task automatic test_backpressure();
    int ref_q[$], exp[$];
    logic [19:0] b[$];
    logic [19:0] k;
    k = 20'($urandom);
    b = '{20'($urandom), 20'($urandom)};
    model(k, 2, b, exp);
    do_cmd(k, 2, b, 0, -1, -1);
    ref_q = got_q;
    do_cmd(k, 2, b, 0, 2, -1);
    tests_run++;
    if (!same(got_q, ref_q) || !same(got_q, exp)) begin
      fails++; $display("FAIL backpressure seq: got %p want %p", got_q, exp);
    end
    tests_run++;
    if (hold_viol != 0) begin
      fails++; $display("FAIL backpressure hold: got %0d violations want 0", hold_viol);
    end
  endtask

  task automatic test_n0();
    logic [19:0] b[$];
    b = {};
    do_cmd(20'($urandom), 0, b, 0, -1, -1);
    tests_run++;
    if (first_done !== 1'b1 || done_cnt != 1) begin
      fails++; $display("FAIL n0 done: got %b cnt %0d want 1 cnt 1", first_done, done_cnt);
    end
    tests_run++;
    if (got_q.size() != 0 || outv_seen != 0 || inr_seen != 0) begin
      fails++; $display("FAIL n0 quiet: got samples %0d out_valid %0d in_ready %0d want 0/0/0",
                        got_q.size(), outv_seen, inr_seen);
    end
    tests_run++;
    if (cmdrdy_after !== 1'b1) begin
      fails++; $display("FAIL n0 cmd_ready: got %b want 1", cmdrdy_after);
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] obs;
    logic [19:0] b[$];
    b = '{20'($urandom), 20'($urandom), 20'($urandom)};
    do_cmd(20'($urandom) | 20'h1, 3, b, 0, -1, 5);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    obs = {bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, busy, done};
    tests_run++;
    if (timed_out || obs !== {1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_mid values: got %b want %b", obs, 18'b100_000000000000_000);
    end
    rst = 0;
    test_identity("after_reset");
  endtask

  task automatic test_back_to_back();
    int exp[$];
    logic [19:0] b[$];
    logic [19:0] k;
    int n;
    for (int it = 0; it < 8; it++) begin
      k = 20'($urandom);
      n = $urandom_range(1, 4);
      b = {};
      for (int i = 0; i < n; i++) b.push_back(20'($urandom));
      model(k, n, b, exp);
      do_cmd(k, n, b, 1, -1, -1);
      tests_run++;
      if (timed_out || cmd_acc !== 1'b1 || !same(got_q, exp)) begin
        fails++; $display("FAIL random%0d seq: got %p want %p", it, got_q, exp);
      end
      tests_run++;
      if (hold_viol != 0 || last_idx != exp.size() - 1) begin
        fails++; $display("FAIL random%0d hold/last: got viol %0d last %0d want 0/%0d", it,
                          hold_viol, last_idx, exp.size() - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity("identity");
    test_overlap();
    test_fullscale();
    test_backpressure();
    test_n0();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/conv_stream_seq.md
# conv_stream_seq

Sequencer that runs linear convolution of a 4-tap kernel over an input stream of arbitrary length on the accelerator's 4×4 block-convolution datapath. It sits between the RISC-V custom-instruction command port and the output buffer. It latches a kernel, accepts packed 4-sample input blocks, and drives one block per pass through the datapath. It performs overlap-add across block boundaries and emits one output sample per beat, ending with a 3-sample tail flush.

## Interface
- LANE_W, 5: bits per sample/tap lane; a packed word is 4 lanes, x0/h0 in the LSBs.
- ACC_W, 12: output sample width; must be ≥ 2*LANE_W+2.
- NBLK_W, 8: width of the block-count field.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_kernel  in  4*LANE_W  taps h0..h3, latched on command handshake.
- cmd_nblk  in  NBLK_W  number of 4-sample input blocks N; 0 is legal.
- in_valid  in  1  input block valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  4*LANE_W  samples x0..x3, unsigned.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accept.
- out_data  out  ACC_W  output sample, unsigned.
- out_last  out  1  marks final sample (index 4N+2).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of command.

## Operation
- States: IDLE, LOAD, EMIT, FLUSH, DONE.
- IDLE: on cmd_valid&&cmd_ready, latch kernel and N, clear overlap regs ov0..ov2. Go to LOAD if N>0, else DONE.
- LOAD: on in_valid&&in_ready, compute datapath y0..y6, full precision, unsigned.
  - Stage s0=y0+ov0, s1=y1+ov1, s2=y2+ov2, s3=y3.
  - Update ov0..ov2 := y4..y6.
  - Decrement block counter. Go to EMIT.
- EMIT: present s0..s3 in order, one per out handshake. After s3 accepted: go to LOAD if blocks remain, else FLUSH.
- FLUSH: present ov0, ov1, ov2. out_last=1 with ov2. After ov2 accepted, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Total output per command: 4N+3 samples; N=0 produces none.
- Arithmetic: every sum fits ACC_W with the defaults (max 4·31·31=3844). No saturation or wrap logic is required.
- out_valid holds until accepted. out_data and out_last stay stable while out_valid&&!out_ready.
- Input is never accepted while samples are pending; in_ready=0 in EMIT and FLUSH.
- Kernel and N changes on cmd_* after acceptance have no effect.
- rst at any time: return to IDLE, discard staged and overlap data, clear counters. No partial output after reset.

## Timing
- Reset values:
  - cmd_ready=1 (IDLE); in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - ov0..ov2=0, counter=0.
- Command accept at cycle t → in_ready=1 at t+1 (N>0), or done=1 at t+1 (N=0).
- Block accept at cycle t → out_valid=1 with s0 at t+1. Outputs are registered, with no combinational in→out path.
- With out_ready held high: one sample per cycle, and in_ready reasserts the cycle after s3 is accepted. Steady state is 5 cycles per block.
- Last sample accepted at t → done pulse at t+1, cmd_ready=1 at t+2.
- A new command may be accepted the cycle cmd_ready returns high.

## Structure
- Shared package conv_pkg holds:
  - LANE_W/ACC_W defaults and TAPS=4.
  - The state enum (IDLE, LOAD, EMIT, FLUSH, DONE).
  - Lane-unpack helper functions.
- One sub-module, conv_block4: combinational 4×4 full linear convolution. It takes packed x and h and returns seven ACC_W-bit outputs without truncation. The sequencer instantiates it once, fed from the latched kernel and in_data.
- The sequencer itself holds the FSM, the block counter, the 2-bit emit index, the s0..s3 staging regs and ov0..ov2.

## Test plan
- Identity: h=[1,0,0,0], N=1, x=[3,5,7,9] → 3,5,7,9,0,0,0; out_last on the 7th sample; done one cycle after.
- Overlap-add: h=[1,1,1,1], N=2, both blocks [1,1,1,1] → 1,2,3,4,4,4,4,4,3,2,1; 11 samples.
- Full-scale: h=x=all 31, N=2 → 961,1922,2883,3844,3844,3844,3844,3844,2883,1922,961; no wrap.
- Backpressure: out_ready low for 5 cycles mid-EMIT → out_data/out_last stable, in_ready=0, no sample lost or duplicated. Sequence matches the unstalled run.
- N=0: command accepted → done pulse next cycle; out_valid never asserts; in_ready never asserts.
- Reset mid-operation: assert rst during EMIT of block 2 of N=3 → next cycle all outputs at reset values with cmd_ready=1. A fresh identity command then yields exactly 3,5,7,9,0,0,0, confirming no stale overlap.
